// File: rtl/redux_pkg.sv
// Shared definitions for the Redux-V datapath.
//   - ALU opcode values (the ula Seletor encoding)
//   - controller FSM state type
//   - bit positions of the fields inside an 8-bit instruction
package redux_pkg;

   localparam logic [3:0] OP_NOT  = 4'd0;
   localparam logic [3:0] OP_AND  = 4'd1;
   localparam logic [3:0] OP_OR   = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd3;
   localparam logic [3:0] OP_ADD  = 4'd4;
   localparam logic [3:0] OP_SUB  = 4'd5;
   localparam logic [3:0] OP_SLR  = 4'd6;
   localparam logic [3:0] OP_SRR  = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_ROL  = 4'd9;
   localparam logic [3:0] OP_LAST = OP_ROL;

   // instr = {opcode[7:4], ra[3:2], rb[1:0]}
   localparam int unsigned INSTR_OP_MSB = 7;
   localparam int unsigned INSTR_OP_LSB = 4;
   localparam int unsigned INSTR_RA_MSB = 3;
   localparam int unsigned INSTR_RA_LSB = 2;
   localparam int unsigned INSTR_RB_MSB = 1;
   localparam int unsigned INSTR_RB_LSB = 0;

   typedef enum logic [1:0] {
      StIdle,
      StDec,
      StExec,
      StWb
   } state_e;

endpackage

// File: rtl/ula.sv
// ula: 8-bit combinational ALU of the Redux-V datapath.
//   A, B     operands
//   Seletor  operation select (see redux_pkg opcodes)
//   S        8-bit result (ADD/SUB/MUL truncated)
//   ZERO     high when S == 0
// Unused selector values produce S = 0.
module ula
   import redux_pkg::*;
(
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic [3:0] Seletor,
   output logic       ZERO,
   output logic [7:0] S
);

   logic [15:0] prod;

   always_comb begin
      prod = {8'b0, A} * {8'b0, B};
      S    = 8'h00;
      unique case (Seletor)
         OP_NOT:  S = ~A;
         OP_AND:  S = A & B;
         OP_OR:   S = A | B;
         OP_XOR:  S = A ^ B;
         OP_ADD:  S = A + B;
         OP_SUB:  S = A - B;
         OP_SLR:  S = A << 1;
         OP_SRR:  S = A >> 1;
         OP_MUL:  S = prod[7:0];
         OP_ROL:  S = {A[6:0], A[7]};
         default: S = 8'h00;
      endcase
      ZERO = (S == 8'h00);
   end

endmodule

// File: rtl/ula_ctrl.sv
// ula_ctrl: multi-cycle sequencer around a 4 x 8-bit register bank and the ula ALU.
// Each accepted instruction runs IDLE -> DEC -> EXEC -> WB and writes R[ra] op R[rb]
// back to R[ra] (legal opcodes only).
//   clk, rst                 clock, asynchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (ready only in IDLE)
//   instr                    {opcode, ra, rb}
//   ld_en/ld_addr/ld_data    direct register load, honoured in IDLE only
//   rd_addr/rd_data          combinational debug read port
//   done                     one-cycle pulse in WB
//   illegal                  pulse with done when opcode > 9
//   zero_flag                ZERO of the last legal retired instruction
module ula_ctrl
   import redux_pkg::*;
#(
   parameter int unsigned NREGS = 4,
   parameter int unsigned W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         instr_valid,
   output logic         instr_ready,
   input  logic [7:0]   instr,
   input  logic         ld_en,
   input  logic [1:0]   ld_addr,
   input  logic [W-1:0] ld_data,
   input  logic [1:0]   rd_addr,
   output logic [W-1:0] rd_data,
   output logic         done,
   output logic         illegal,
   output logic         zero_flag
);

   state_e       state_q, state_d;
   logic [7:0]   instr_q, instr_d;
   logic [W-1:0] opa_q, opa_d, opb_q, opb_d;
   logic [3:0]   sel_q, sel_d;
   logic         ill_q, ill_d;
   logic [W-1:0] res_q, res_d;
   logic         zf_q, zf_d;
   logic         zero_flag_q, zero_flag_d;
   logic [W-1:0] regs_q [NREGS];

   logic         wr_en;
   logic [1:0]   wr_addr;
   logic [W-1:0] wr_data;

   logic [W-1:0] alu_s;
   logic         alu_zero;

   logic [3:0]   op_f;
   logic [1:0]   ra_f, rb_f;

   assign op_f = instr_q[INSTR_OP_MSB:INSTR_OP_LSB];
   assign ra_f = instr_q[INSTR_RA_MSB:INSTR_RA_LSB];
   assign rb_f = instr_q[INSTR_RB_MSB:INSTR_RB_LSB];

   ula u_ula (
      .A       (opa_q),
      .B       (opb_q),
      .Seletor (sel_q),
      .ZERO    (alu_zero),
      .S       (alu_s)
   );

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      sel_d       = sel_q;
      ill_d       = ill_q;
      res_d       = res_q;
      zf_d        = zf_q;
      zero_flag_d = zero_flag_q;
      wr_en       = 1'b0;
      wr_addr     = ld_addr;
      wr_data     = ld_data;
      instr_ready = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;

      unique case (state_q)
         StIdle: begin
            instr_ready = 1'b1;
            // Load lands at the handshake edge too, so DEC sees the new value.
            wr_en = ld_en;
            if (instr_valid) begin
               instr_d = instr;
               state_d = StDec;
            end
         end
         StDec: begin
            opa_d   = regs_q[ra_f];
            opb_d   = regs_q[rb_f];
            sel_d   = op_f;
            ill_d   = (op_f > OP_LAST);
            state_d = StExec;
         end
         StExec: begin
            res_d   = alu_s;
            zf_d    = alu_zero;
            state_d = StWb;
         end
         StWb: begin
            done    = 1'b1;
            illegal = ill_q;
            if (!ill_q) begin
               wr_en       = 1'b1;
               wr_addr     = ra_f;
               wr_data     = res_q;
               zero_flag_d = zf_q;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         instr_q     <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         sel_q       <= '0;
         ill_q       <= 1'b0;
         res_q       <= '0;
         zf_q        <= 1'b0;
         zero_flag_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         sel_q       <= sel_d;
         ill_q       <= ill_d;
         res_q       <= res_d;
         zf_q        <= zf_d;
         zero_flag_q <= zero_flag_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data   = regs_q[rd_addr];
   assign zero_flag = zero_flag_q;

endmodule
